// File: rtl/pcm_dac_pkg.sv
// ============================================================================
// Module   : pcm_dac_pkg
// Brief    : Shared PCM width and gain-state encoding for the DAC feeder path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pcm_dac_pkg;

    localparam int PCM_W = 20;

    typedef enum logic [1:0] {
        GS_MUTED     = 2'd0,
        GS_RAMP_UP   = 2'd1,
        GS_PLAY      = 2'd2,
        GS_RAMP_DOWN = 2'd3
    } gain_state_t;

    // Counter width that stays at least one bit for a modulus of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pcm_fifo2.sv
// ============================================================================
// Module   : pcm_fifo2
// Brief    : Two-entry FIFO with push/pop and full/empty flags for audio feeders.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pcm_fifo2 #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign pop_data = mem_q[rd_ptr_q];

    // Flags are pre-edge, so a push while full is refused even with a pop.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pcm_dac_sched.sv
// ============================================================================
// Module   : pcm_dac_sched
// Brief    : Tick strobe, sample-slot scheduler and mute gain ramp feeding the
//            delta-sigma modulator's clk_ena / pcm_in.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pcm_dac_sched
    import pcm_dac_pkg::*;
#(
    parameter int ENA_DIV = 4,
    parameter int OSR     = 64,
    parameter int RAMP_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mute,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PCM_W-1:0] s_pcm,
    output logic             dac_ena,
    output logic [PCM_W-1:0] dac_pcm,
    output logic             underrun,
    output logic [1:0]       gain_state
);

    localparam int ENA_W  = cnt_width(ENA_DIV);
    localparam int OSR_W  = cnt_width(OSR);
    localparam int G_W    = RAMP_W + 1;
    localparam int PROD_W = PCM_W + RAMP_W + 2;

    localparam logic [ENA_W-1:0] ENA_LAST = ENA_W'(ENA_DIV - 1);
    localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);
    localparam logic [G_W-1:0]   G_FULL   = {1'b1, {RAMP_W{1'b0}}};
    localparam logic [G_W-1:0]   G_ONE    = G_W'(1);

    logic [ENA_W-1:0]        ena_cnt_q, ena_cnt_d;
    logic [OSR_W-1:0]        osr_cnt_q, osr_cnt_d;
    logic signed [PCM_W-1:0] cur_q, cur_d;
    logic [G_W-1:0]          g_q, g_d;
    gain_state_t             state_q, state_d;
    logic [PCM_W-1:0]        dac_pcm_q, dac_pcm_d;
    logic                    alive_q, alive_d;

    logic                    tick;
    logic                    slot;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [PCM_W-1:0]        fifo_data;
    logic signed [PROD_W-1:0] cur_ext, g_ext, prod;

    assign tick       = (ena_cnt_q == ENA_LAST);
    assign slot       = tick & (osr_cnt_q == OSR_LAST);
    assign dac_ena    = tick;
    assign underrun   = slot & fifo_empty;
    // alive_q holds ready low until the first edge after reset release.
    assign s_ready    = alive_q & ~fifo_full;
    assign dac_pcm    = dac_pcm_q;
    assign gain_state = state_q;

    pcm_fifo2 #(
        .W (PCM_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s_valid & s_ready),
        .push_data (s_pcm),
        .pop       (slot),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        alive_d   = 1'b1;
        ena_cnt_d = tick ? '0 : ena_cnt_q + ENA_W'(1);
        osr_cnt_d = osr_cnt_q;
        if (tick) begin
            osr_cnt_d = (osr_cnt_q == OSR_LAST) ? '0 : osr_cnt_q + OSR_W'(1);
        end
        cur_d = (slot && !fifo_empty) ? fifo_data : cur_q;

        state_d = state_q;
        g_d     = g_q;
        if (tick) begin
            case (state_q)
                GS_MUTED: begin
                    if (!mute) begin
                        g_d     = G_ONE;
                        state_d = GS_RAMP_UP;
                    end else begin
                        g_d = '0;
                    end
                end
                GS_PLAY: begin
                    if (mute) begin
                        g_d     = G_FULL - G_ONE;
                        state_d = GS_RAMP_DOWN;
                    end else begin
                        g_d = G_FULL;
                    end
                end
                // Both ramp states follow mute directly, so a reversal never jumps g.
                GS_RAMP_UP, GS_RAMP_DOWN: begin
                    if (mute) begin
                        g_d     = g_q - G_ONE;
                        state_d = (g_d == '0) ? GS_MUTED : GS_RAMP_DOWN;
                    end else begin
                        g_d     = g_q + G_ONE;
                        state_d = (g_d == G_FULL) ? GS_PLAY : GS_RAMP_UP;
                    end
                end
                default: begin
                    g_d     = '0;
                    state_d = GS_MUTED;
                end
            endcase
        end

        cur_ext   = PROD_W'(cur_d);
        g_ext     = PROD_W'(g_d);
        prod      = cur_ext * g_ext;
        dac_pcm_d = tick ? PCM_W'(prod >>> RAMP_W) : dac_pcm_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ena_cnt_q <= '0;
            osr_cnt_q <= '0;
            cur_q     <= '0;
            g_q       <= '0;
            state_q   <= GS_MUTED;
            dac_pcm_q <= '0;
            alive_q   <= 1'b0;
        end else begin
            ena_cnt_q <= ena_cnt_d;
            osr_cnt_q <= osr_cnt_d;
            cur_q     <= cur_d;
            g_q       <= g_d;
            state_q   <= state_d;
            dac_pcm_q <= dac_pcm_d;
            alive_q   <= alive_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pcm_dac_sched.sv
// ============================================================================
// Module   : tb_pcm_dac_sched
// Brief    : Self-checking bench for pcm_dac_sched (ENA_DIV=4, OSR=8, RAMP_W=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pcm_dac_sched;

    localparam int ENA_DIV = 4;
    localparam int OSR     = 8;
    localparam int RAMP_W  = 2;
    localparam int FULL    = 1 << RAMP_W;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        mute    = 1'b1;
    logic        s_valid = 1'b0;
    logic [19:0] s_pcm   = '0;
    logic        s_ready;
    logic        dac_ena;
    logic [19:0] dac_pcm;
    logic        underrun;
    logic [1:0]  gain_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pcm_dac_sched #(
        .ENA_DIV (ENA_DIV),
        .OSR     (OSR),
        .RAMP_W  (RAMP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mute       (mute),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_pcm      (s_pcm),
        .dac_ena    (dac_ena),
        .dac_pcm    (dac_pcm),
        .underrun   (underrun),
        .gain_state (gain_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: edge count, tick count, sample queue, integer gain.
    int m_cyc   = 0;
    int m_ticks = 0;
    bit m_alive = 0;
    int m_q[$];
    int m_cur   = 0;
    int m_g     = 0;
    int m_pcm   = 0;
    int m_state = 0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_cyc = 0; m_ticks = 0; m_alive = 0; m_q.delete();
            m_cur = 0; m_g = 0; m_pcm = 0; m_state = 0;
        end else begin
            bit tick, slot, push;
            tick = (m_cyc % ENA_DIV) == ENA_DIV - 1;
            slot = tick && ((m_ticks % OSR) == OSR - 1);
            push = s_valid && m_alive && (m_q.size() < 2);
            if (slot && m_q.size() > 0) m_cur = m_q.pop_front();
            if (push) m_q.push_back(int'($signed(s_pcm)));
            if (tick) begin
                if (mute) m_g = (m_g > 0) ? m_g - 1 : 0;
                else      m_g = (m_g < FULL) ? m_g + 1 : FULL;
                if (m_g == 0)         m_state = 0;
                else if (m_g == FULL) m_state = 2;
                else                  m_state = mute ? 3 : 1;
                m_pcm = (m_cur * m_g) >>> RAMP_W;
                m_ticks++;
            end
            m_cyc++;
            m_alive = 1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            logic [19:0] e_pcm;
            bit e_ena;
            e_pcm = m_pcm[19:0];
            e_ena = (m_cyc % ENA_DIV) == ENA_DIV - 1;
            check("cyc_dac_ena", dac_ena, e_ena);
            check("cyc_s_ready", s_ready, m_alive && (m_q.size() < 2));
            check("cyc_underrun", underrun,
                  e_ena && ((m_ticks % OSR) == OSR - 1) && (m_q.size() == 0));
            check("cyc_dac_pcm", dac_pcm, e_pcm);
            check("cyc_gain_state", gain_state, m_state);
        end
    end

    task automatic next_tick();
        bit seen = 0;
        for (int i = 0; i < 2 * ENA_DIV && !seen; i++) begin
            @(negedge clk);
            if (dac_ena) seen = 1;
        end
        check("tick_seen", seen, 1);
        @(negedge clk);
    endtask

    task automatic tick_expect(input string name, input logic [19:0] pcm, input int st);
        next_tick();
        check({name, "_pcm"}, dac_pcm, pcm);
        check({name, "_state"}, gain_state, st);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ena, n_und, n_nz, n_hs, hs_at[$];
        logic [19:0] up_pcm [4];
        up_pcm = '{20'h10000, 20'h20000, 20'h30000, 20'h40000};

        @(negedge clk); @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_dac_ena", dac_ena, 0);
        check("rst_dac_pcm", dac_pcm, 0);
        check("rst_underrun", underrun, 0);
        check("rst_gain_state", gain_state, 0);
        reset = 1'b0;

        @(negedge clk);
        check("first_ena_c1", dac_ena, 0);
        check("ready_after_rst", s_ready, 1);
        @(negedge clk);
        check("first_ena_c2", dac_ena, 0);
        @(negedge clk);
        check("first_ena_c3", dac_ena, 1);

        // Idle, muted, no samples offered.
        n_ena = 0; n_und = 0; n_nz = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (dac_ena) n_ena++;
            if (underrun) n_und++;
            if (dac_pcm != 0) n_nz++;
        end
        check("idle_ena_count", n_ena, 16);
        check("idle_underrun_count", n_und, 2);
        check("idle_pcm_nonzero", n_nz, 0);
        check("idle_state", gain_state, 0);

        // Continuous source of 0x40000.
        s_pcm   = 20'h40000;
        s_valid = 1'b1;
        @(negedge clk);
        check("ready_after_push1", s_ready, 1);
        @(negedge clk);
        check("ready_after_push2", s_ready, 0);
        n_und = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (s_valid && s_ready) hs_at.push_back(i);
            if (underrun) n_und++;
        end
        check("fed_underrun_count", n_und, 0);
        check("fed_push_count", hs_at.size(), 2);
        if (hs_at.size() == 2) check("fed_pop_spacing", hs_at[1] - hs_at[0], 32);

        next_tick();
        mute = 1'b0;
        for (int k = 0; k < 4; k++) tick_expect("ramp_up", up_pcm[k], (k < 3) ? 1 : 2);
        tick_expect("play_hold", 20'h40000, 2);

        mute = 1'b1;
        tick_expect("down_g3", 20'h30000, 3);
        tick_expect("down_g2", 20'h20000, 3);
        tick_expect("down_g1", 20'h10000, 3);
        tick_expect("down_g0", 20'h00000, 0);

        mute = 1'b0;
        tick_expect("rev_g1", 20'h10000, 1);
        tick_expect("rev_g2", 20'h20000, 1);
        mute = 1'b1;
        tick_expect("rev_back_g1", 20'h10000, 3);
        tick_expect("rev_back_g0", 20'h00000, 0);

        // Replace queued samples with -1 while muted, then step to g=1.
        s_pcm = 20'hFFFFF;
        repeat (25) next_tick();
        mute = 1'b0;
        tick_expect("neg_floor_g1", 20'hFFFFF, 1);

        tick_expect("neg_g2", 20'hFFFFF, 1);
        tick_expect("neg_g3", 20'hFFFFF, 1);
        tick_expect("neg_g4", 20'hFFFFF, 2);
        mute = 1'b1;
        tick_expect("neg_down_g3", 20'hFFFFF, 3);
        @(negedge clk);
        check("pre_rst_fifo_full", s_ready, 0);

        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_s_ready", s_ready, 0);
        check("async_dac_ena", dac_ena, 0);
        check("async_dac_pcm", dac_pcm, 0);
        check("async_underrun", underrun, 0);
        check("async_gain_state", gain_state, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (48) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
